// File: rtl/mul_share_ctrl_if.sv
// Bundle of the signals exchanged by mul_share_ctrl.
// Requester side: req0/a0/b0 and req1/a1/b1, plus the gnt0/gnt1 pulses.
// Multiplier side: mul_a/mul_b go out to the multiplier and mul_m comes back.
// Result side: res, res_valid, res_id and busy.
// The slave modport is used by the controller. The master modport is used by
// whatever sits around it: the requesters, the multiplier and the result consumer.
interface mul_share_ctrl_if;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_m;
  logic [7:0] res;
  logic       res_valid;
  logic       res_id;
  logic       busy;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_m,
    output gnt0, gnt1, mul_a, mul_b, res, res_valid, res_id, busy
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, mul_m,
    input  gnt0, gnt1, mul_a, mul_b, res, res_valid, res_id, busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one combinational 4x4 multiplier between two requesters.
// The two requests are arbitrated round-robin. The winner's operands are
// registered onto mul_a/mul_b. After SETTLE_CYC cycles, mul_m is captured into
// res, tagged with res_id.
//
// Ports:
//   clk  - clock; all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mul_share_ctrl_if.slave:
//            requests, operands and grant pulses
//            multiplier operands and product
//            res/res_valid/res_id and busy
//
// Parameter SETTLE_CYC (1..15): number of cycles the multiplier output is given
// to settle after its operands have been registered.
//
// Optional build macro MUL_ZERO_BYPASS_EN: a grant whose winning operand pair
// contains a zero produces res=0 in the grant cycle and skips the wait.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | accepting requests; a request seen at an edge is granted
// ST_WAIT | operands on the multiplier, counting down the settle time
module mul_share_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  mul_share_ctrl_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_id_q, last_id_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [3:0] mul_a_q, mul_a_d;
  logic [3:0] mul_b_q, mul_b_d;
  logic [7:0] res_q, res_d;
  logic       res_valid_q, res_valid_d;
  logic       res_id_q, res_id_d;

  logic       any_req;
  logic       winner;
  logic [3:0] win_a;
  logic [3:0] win_b;

  assign any_req = bus.req0 | bus.req1;
  // On a tie the requester that did not win last time goes next.
  assign winner  = (bus.req0 & bus.req1) ? ~last_id_q : bus.req1;
  assign win_a   = winner ? bus.a1 : bus.a0;
  assign win_b   = winner ? bus.b1 : bus.b0;

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (win_a == 4'd0) || (win_b == 4'd0);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt0_d    = ~winner;
          gnt1_d    = winner;
          mul_a_d   = win_a;
          mul_b_d   = win_b;
          last_id_d = winner;
`ifdef MUL_ZERO_BYPASS_EN
          if (zero_op) begin
            res_d       = 8'd0;
            res_valid_d = 1'b1;
            res_id_d    = winner;
          end else begin
            cnt_d   = SETTLE_LD;
            state_d = ST_WAIT;
          end
`else
          cnt_d   = SETTLE_LD;
          state_d = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        // last_id_q still names the requester whose operands are on the multiplier.
        if (cnt_q == 4'd1) begin
          res_d       = bus.mul_m;
          res_valid_d = 1'b1;
          res_id_d    = last_id_q;
          cnt_d       = 4'd0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_id_q   <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
      res_q       <= 8'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl.
// Two instances run side by side: one with SETTLE_CYC=1 and one with SETTLE_CYC=4.
// Both receive identical stimulus patterns.
// The reference model works at transaction level. It tracks the edge at which
// each instance becomes free again and the edge at which the pending result
// is due.
module tb_mul_share_ctrl;
  localparam int NDUT = 2;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_share_ctrl_if if_s1 ();
  mul_share_ctrl_if if_s4 ();

  mul_share_ctrl #(.SETTLE_CYC(1)) u_dut_s1 (.clk(clk), .rst(rst), .bus(if_s1.slave));
  mul_share_ctrl #(.SETTLE_CYC(4)) u_dut_s4 (.clk(clk), .rst(rst), .bus(if_s4.slave));

  // Stimulus and observation arrays: index 0 is the SETTLE_CYC=1 instance,
  // index 1 is the SETTLE_CYC=4 instance.
  logic       req0_v[NDUT], req1_v[NDUT];
  logic [3:0] a0_v[NDUT], b0_v[NDUT], a1_v[NDUT], b1_v[NDUT];
  logic       g0_w[NDUT], g1_w[NDUT], rv_w[NDUT], rid_w[NDUT], busy_w[NDUT];
  logic [3:0] ma_w[NDUT], mb_w[NDUT];
  logic [7:0] res_w[NDUT];

  // The multiplier instances that sit next to each controller.
  assign if_s1.mul_m = if_s1.mul_a * if_s1.mul_b;
  assign if_s4.mul_m = if_s4.mul_a * if_s4.mul_b;

  assign if_s1.req0 = req0_v[0];
  assign if_s1.a0   = a0_v[0];
  assign if_s1.b0   = b0_v[0];
  assign if_s1.req1 = req1_v[0];
  assign if_s1.a1   = a1_v[0];
  assign if_s1.b1   = b1_v[0];
  assign if_s4.req0 = req0_v[1];
  assign if_s4.a0   = a0_v[1];
  assign if_s4.b0   = b0_v[1];
  assign if_s4.req1 = req1_v[1];
  assign if_s4.a1   = a1_v[1];
  assign if_s4.b1   = b1_v[1];

  assign g0_w[0] = if_s1.gnt0;  assign g0_w[1] = if_s4.gnt0;
  assign g1_w[0] = if_s1.gnt1;  assign g1_w[1] = if_s4.gnt1;
  assign rv_w[0] = if_s1.res_valid;  assign rv_w[1] = if_s4.res_valid;
  assign rid_w[0] = if_s1.res_id;  assign rid_w[1] = if_s4.res_id;
  assign busy_w[0] = if_s1.busy;  assign busy_w[1] = if_s4.busy;
  assign ma_w[0] = if_s1.mul_a;  assign ma_w[1] = if_s4.mul_a;
  assign mb_w[0] = if_s1.mul_b;  assign mb_w[1] = if_s4.mul_b;
  assign res_w[0] = if_s1.res;  assign res_w[1] = if_s4.res;

  int checks = 0;
  int errors = 0;
  int sett[NDUT];

  // Reference model state.
  int ecnt;
  int free_e[NDUT];
  bit pend[NDUT];
  int cap_e[NDUT];
  bit cap_id[NDUT];
  int cap_p[NDUT];
  bit m_last[NDUT];
  bit x_g0[NDUT], x_g1[NDUT], x_rv[NDUT], x_busy[NDUT], x_id[NDUT];
  int x_ma[NDUT], x_mb[NDUT], x_res[NDUT];

  // Records of observed grants and results.
  int ng[NDUT], nr[NDUT];
  int g_ord[NDUT][8], g_cyc[NDUT][8];
  int r_id[NDUT][8], r_res[NDUT][8];
  int g_cyc_id[NDUT][2];
  bit gzero[NDUT][2];

  typedef struct {
    bit r0; bit r1;
    logic [3:0] a0; logic [3:0] b0; logic [3:0] a1; logic [3:0] b1;
    int id_a; int res_a; int id_b; int res_b;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d, expected %0d", d, nm, act, exp);
    end
  endtask

  task automatic model_reset_one(input int d);
    free_e[d] = 0;
    pend[d]   = 1'b0;
    m_last[d] = 1'b1;
    x_g0[d] = 0; x_g1[d] = 0; x_rv[d] = 0; x_busy[d] = 0; x_id[d] = 0;
    x_ma[d] = 0; x_mb[d] = 0; x_res[d] = 0;
  endtask

  task automatic model_reset_all();
    for (int d = 0; d < NDUT; d++) model_reset_one(d);
  endtask

  // Applies the inputs sampled at the edge that has just passed.
  task automatic model_edge();
    for (int d = 0; d < NDUT; d++) begin
      x_g0[d] = 0; x_g1[d] = 0; x_rv[d] = 0;
      if (rst) begin
        model_reset_one(d);
      end else begin
        if (pend[d] && ecnt == cap_e[d]) begin
          x_res[d] = cap_p[d]; x_rv[d] = 1; x_id[d] = cap_id[d]; pend[d] = 0;
        end
        if (ecnt >= free_e[d] && (req0_v[d] || req1_v[d])) begin
          bit w;
          int pa, pb;
          if (req0_v[d] && req1_v[d]) w = (m_last[d] == 1'b1) ? 1'b0 : 1'b1;
          else w = req1_v[d];
          pa = w ? int'(a1_v[d]) : int'(a0_v[d]);
          pb = w ? int'(b1_v[d]) : int'(b0_v[d]);
          x_g0[d] = !w; x_g1[d] = w; x_ma[d] = pa; x_mb[d] = pb; m_last[d] = w;
          if (BYPASS && (pa == 0 || pb == 0)) begin
            x_res[d] = 0; x_rv[d] = 1; x_id[d] = w; free_e[d] = ecnt + 1;
          end else begin
            pend[d] = 1; cap_e[d] = ecnt + sett[d]; cap_id[d] = w; cap_p[d] = pa * pb;
            free_e[d] = ecnt + sett[d] + 1;
          end
        end
        x_busy[d] = (ecnt + 1 < free_e[d]);
      end
    end
    ecnt++;
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      chk(d, "gnt0", 32'(g0_w[d]), 32'(x_g0[d]));
      chk(d, "gnt1", 32'(g1_w[d]), 32'(x_g1[d]));
      chk(d, "res_valid", 32'(rv_w[d]), 32'(x_rv[d]));
      chk(d, "busy", 32'(busy_w[d]), 32'(x_busy[d]));
      chk(d, "mul_a", 32'(ma_w[d]), x_ma[d]);
      chk(d, "mul_b", 32'(mb_w[d]), x_mb[d]);
      chk(d, "res", 32'(res_w[d]), x_res[d]);
      chk(d, "res_id", 32'(rid_w[d]), 32'(x_id[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic clear_rec();
    for (int d = 0; d < NDUT; d++) begin
      ng[d] = 0; nr[d] = 0;
      for (int i = 0; i < 8; i++) begin
        g_ord[d][i] = 0; g_cyc[d][i] = 0; r_id[d][i] = 0; r_res[d][i] = 0;
      end
    end
  endtask

  // Requester behaviour: drop the request once its grant is seen.
  // Also records grants and results, and checks result latency.
  task automatic react();
    for (int d = 0; d < NDUT; d++) begin
      if (rv_w[d] === 1'b1) begin
        int rid;
        int lat;
        rid = int'(rid_w[d]);
        lat = (BYPASS && gzero[d][rid]) ? 0 : sett[d];
        chk(d, "latency", ecnt - g_cyc_id[d][rid], lat);
        if (nr[d] < 8) begin r_id[d][nr[d]] = rid; r_res[d][nr[d]] = int'(res_w[d]); end
        nr[d]++;
      end
      if (g0_w[d] === 1'b1 || g1_w[d] === 1'b1) begin
        int gid;
        gid = (g1_w[d] === 1'b1) ? 1 : 0;
        g_cyc_id[d][gid] = ecnt;
        gzero[d][gid] = gid ? (a1_v[d] == 0 || b1_v[d] == 0) : (a0_v[d] == 0 || b0_v[d] == 0);
        if (ng[d] < 8) begin g_ord[d][ng[d]] = gid; g_cyc[d][ng[d]] = ecnt; end
        ng[d]++;
        if (gid == 1) req1_v[d] = 1'b0;
        else req0_v[d] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n, input int maxcyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxcyc && !done; c++) begin
      step();
      react();
      if (nr[0] >= n && nr[1] >= n) done = 1'b1;
    end
    chk(9, "run_done", 32'(done), 32'd1);
  endtask

  task automatic set_all(input bit r0, input bit r1, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1);
    for (int d = 0; d < NDUT; d++) begin
      req0_v[d] = r0; req1_v[d] = r1;
      a0_v[d] = a0; b0_v[d] = b0; a1_v[d] = a1; b1_v[d] = b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    sett[0] = 1; sett[1] = 4;
    ecnt = 0;
    for (int d = 0; d < NDUT; d++) begin g_cyc_id[d][0] = 0; g_cyc_id[d][1] = 0; gzero[d][0] = 0; gzero[d][1] = 0; end
    vt[0] = '{1'b1, 1'b0, 4'd3,  4'd5,  4'd0, 4'd0, 0, 15,  0, 0};
    vt[1] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd9, 4'd6, 1, 54,  0, 0};
    vt[2] = '{1'b1, 1'b1, 4'd15, 4'd15, 4'd2, 4'd7, 0, 225, 1, 14};
    vt[3] = '{1'b1, 1'b1, 4'd0,  4'd11, 4'd4, 4'd4, 0, 0,   1, 16};
    vt[4] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd15, 4'd15, 1, 225, 0, 0};
    vt[5] = '{1'b1, 1'b1, 4'd1,  4'd1,  4'd7, 4'd0, 0, 1,   1, 0};
    vt[6] = '{1'b1, 1'b0, 4'd0,  4'd0,  4'd0, 4'd0, 0, 0,   0, 0};

    clear_rec();
    set_all(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset_all();
    step();
    step();
    rst = 1'b0;
    step();

    // Both requesters held from reset: requester 0 first, then requester 1.
    clear_rec();
    set_all(1, 1, 4'd15, 4'd15, 4'd2, 4'd7);
    run(2, 40);
    for (int d = 0; d < NDUT; d++) begin
      chk(d, "alt_first_id", r_id[d][0], 0);
      chk(d, "alt_first_res", r_res[d][0], 225);
      chk(d, "alt_second_id", r_id[d][1], 1);
      chk(d, "alt_second_res", r_res[d][1], 14);
      chk(d, "alt_grant_order", g_ord[d][1], 1);
    end

    // Table of single operations.
    for (int i = 0; i < 7; i++) begin
      int n;
      clear_rec();
      set_all(vt[i].r0, vt[i].r1, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1);
      n = int'(vt[i].r0) + int'(vt[i].r1);
      run(n, 60);
      for (int d = 0; d < NDUT; d++) begin
        chk(d, "vec_id_a", r_id[d][0], vt[i].id_a);
        chk(d, "vec_res_a", r_res[d][0], vt[i].res_a);
        if (n == 2) begin
          chk(d, "vec_id_b", r_id[d][1], vt[i].id_b);
          chk(d, "vec_res_b", r_res[d][1], vt[i].res_b);
        end
      end
    end

    // Request raised during WAIT is only taken once the controller is idle.
    clear_rec();
    set_all(0, 1, 4'd0, 4'd0, 4'd9, 4'd6);
    step(); react();
    step(); react();
    for (int d = 0; d < NDUT; d++) begin req0_v[d] = 1'b1; a0_v[d] = 4'd3; b0_v[d] = 4'd5; end
    run(2, 40);
    for (int d = 0; d < NDUT; d++) begin
      chk(d, "wait_first_res", r_res[d][0], 54);
      chk(d, "wait_second_id", g_ord[d][1], 0);
      chk(d, "wait_grant_gap", g_cyc[d][1] - g_cyc[d][0], sett[d] + 1);
      chk(d, "wait_second_res", r_res[d][1], 15);
    end

    // Reset in the middle of an operation.
    clear_rec();
    set_all(1, 1, 4'd5, 4'd5, 4'd6, 4'd6);
    step();
    for (int d = 0; d < NDUT; d++) chk(d, "pre_rst_gnt1", 32'(g1_w[d]), 32'd1);
    #2;
    rst = 1'b1;
    model_reset_all();
    #1;
    check_all();
    step();
    step();
    rst = 1'b0;
    clear_rec();
    run(2, 40);
    for (int d = 0; d < NDUT; d++) begin
      chk(d, "post_rst_first_id", r_id[d][0], 0);
      chk(d, "post_rst_first_res", r_res[d][0], 25);
      chk(d, "post_rst_second_res", r_res[d][1], 36);
    end

    // Random traffic against the model, with occasional mid-cycle resets.
    for (int c = 0; c < 1500; c++) begin
      clear_rec();
      step();
      react();
      for (int d = 0; d < NDUT; d++) begin
        if (!req0_v[d] && $urandom_range(0, 2) == 0) begin
          req0_v[d] = 1'b1;
          a0_v[d] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          b0_v[d] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        if (!req1_v[d] && $urandom_range(0, 2) == 0) begin
          req1_v[d] = 1'b1;
          a1_v[d] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          b1_v[d] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        model_reset_all();
        #1;
        check_all();
        step();
        rst = 1'b0;
      end
    end

    set_all(0, 0, 0, 0, 0, 0);
    repeat (10) begin
      step();
      react();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencing and arbitration controller that shares one combinational 4x4 array multiplier instance between two requesters.
- The multiplier takes 4-bit a/b and produces an 8-bit product.
- Arbitrates round-robin, registers the selected operands onto the multiplier inputs, and waits a programmable settle time. It then captures the 8-bit product into a result register tagged with the requester ID.
- Sits between operand-producing blocks and the multiplier instance, which is instantiated alongside it at the level above.

Parameters:
SETTLE_CYC, 1, cycles allowed for the multiplier output to settle after operands are registered; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request; level, held until gnt0 seen
a0  input  4  requester 0 multiplicand
b0  input  4  requester 0 multiplier
req1  input  1  requester 1 request
a1  input  4  requester 1 multiplicand
b1  input  4  requester 1 multiplier
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
mul_a  output  4  registered operand to multiplier input a
mul_b  output  4  registered operand to multiplier input b
mul_m  input  8  product from multiplier instance
res  output  8  captured product
res_valid  output  1  one-cycle pulse: res/res_id valid
res_id  output  1  requester that owns res
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; gnt0=gnt1=0; mul_a=mul_b=0; res=0; res_valid=0; res_id=0; settle counter=0; round-robin pointer last_id=1, so requester 0 wins the first tie.
- States: IDLE, WAIT.
- IDLE: at the edge where req0|req1 is sampled high:
  - pick the winner, latch its a/b into mul_a/mul_b;
  - pulse the matching gnt for the next cycle and set last_id=winner;
  - load the counter with SETTLE_CYC; go to WAIT.
  - No request: stay in IDLE, all pulses 0.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the requester != last_id wins.
- WAIT: the counter decrements each edge. At the edge where the counter equals 1:
  - res<=mul_m, res_id<=winner, res_valid pulses for the next cycle;
  - state returns to IDLE.
- Latency: req sampled at edge k -> gnt high during cycle k+1 -> res_valid high during cycle k+SETTLE_CYC+1.
- Throughput: one operation per SETTLE_CYC+1 cycles; a new grant may be issued at the edge immediately after res_valid is set.
- Requests are ignored while in WAIT. A requester must drop req in response to its gnt (registered). Any req high when the controller is in IDLE is a new request.
- mul_a/mul_b hold their value until the next grant and are not cleared on completion.
- res holds until the next capture.
- Arithmetic: no widening or truncation; res is exactly mul_m, 8 bits, with max 15*15=225.
- Reset mid-WAIT aborts the operation: no res_valid, no gnt, pointer restored to 1.

Optional Feature:
MUL_ZERO_BYPASS_EN
- Defined: in IDLE, if the winner's a==0 or b==0:
  - grant as normal, but skip WAIT;
  - res<=0 and res_valid pulse in the same cycle as gnt (cycle k+1); state stays IDLE;
  - mul_a/mul_b are still updated.
- Undefined: zero operands take the normal SETTLE_CYC path and res=0 arrives with standard latency.

Test Plan:
- SETTLE_CYC=1, req0 with a0=3,b0=5 at edge k -> gnt0 in cycle k+1; res=15, res_valid=1, res_id=0 in cycle k+2; busy high only in cycle k+1.
- req0 and req1 both held from reset, a0=15,b0=15, a1=2,b1=7, each dropping req after its gnt -> gnt0 first, res=225 id 0; then gnt1, res=14 id 1; grants strictly alternate.
- SETTLE_CYC=4, req1 a1=9,b1=6 -> res_valid exactly 5 cycles after the grant edge, res=54; req0 pulsed during WAIT is ignored and serviced only after return to IDLE.
- Assert rst during WAIT -> all outputs 0 immediately; no res_valid after release; next tie grants requester 0.
- MUL_ZERO_BYPASS_EN defined, req0 a0=0,b0=11 -> gnt0 and res_valid=1, res=0 in the same cycle; without the macro, res_valid arrives SETTLE_CYC cycles later.
